sqrt_shift_reg: RTL and testbench
=================================

# sqrt_shift_reg

Parametrised multi-mode shift register with an integrated iteration counter. It is the register primitive of the square-root datapath and replaces the single-bit enable flip-flop. Each instance holds one WIDTH-bit operand: the radicand, partial remainder or root. It supports load, hold, left shift by STEP bits with serial fill, and logical right shift by one. It counts left-shift iterations and flags completion so the sqrt controller can sequence the algorithm.

## Interface
- WIDTH, 16, register width in bits; must be a multiple of STEP
- STEP, 2, bits shifted in per left-shift operation; 1 ≤ STEP < WIDTH
- ITER, WIDTH/STEP, number of left shifts before done asserts; ≥ 1
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  2  operation select: 00 HOLD, 01 LOAD, 10 SHL, 11 SHR
- d  in  WIDTH  parallel load data
- sin  in  STEP  serial fill bits for SHL, entering at the LSBs
- q  out  WIDTH  register contents
- cnt  out  CW = $clog2(ITER+1)  completed left-shift count
- done  out  1  high when cnt == ITER
- sout  out  STEP  bits most recently shifted out of the MSBs (present only with SHREG_SOUT_EN)

## Operation
- Reset (rst=1, asynchronous): q=0, cnt=0, done=0, sout=0. Reset overrides everything while high.
- HOLD: q, cnt, done and sout all hold.
- LOAD: q←d, cnt←0, done←0, sout←0. LOAD while done=1 is legal and restarts the sequence.
- SHL when done=0:
  - q←{q[WIDTH-STEP-1:0], sin}
  - sout←q[WIDTH-1:WIDTH-STEP]
  - cnt←cnt+1
  - done←1 if cnt+1 == ITER
- SHL when done=1: ignored. q, cnt and sout hold. The counter saturates at ITER and never wraps.
- SHR: q←{1'b0, q[WIDTH-1:1]}. Logical shift; cnt, done and sout are unaffected. SHR is allowed in any state.
- Counter and done are fully registered. done is never decoded combinationally from inputs.

## Timing
- Every operation takes effect on the rising edge where mode is sampled. Outputs are valid one clock later; latency is 1 cycle.
- done rises on the same edge on which cnt reaches ITER, i.e. the edge of the ITER-th SHL.
- Reset asserted mid-sequence clears state immediately, without waiting for clk. Release is synchronous to the following clock edges; the first operation is sampled on the first rising edge with rst=0.
- No handshake: the controller must present mode every cycle. HOLD is the idle encoding.

## Configuration
- SHREG_SOUT_EN defined:
  - sout port exists and is updated as described in Operation.
  - Feeds the shifted-out bits into the remainder register of the sqrt datapath.
- SHREG_SOUT_EN undefined:
  - sout port and its register are absent.
  - All other behaviour is identical.

## Structure
- Shared package shreg_pkg holds:
  - typedef enum logic [1:0] shreg_mode_t with MODE_HOLD, MODE_LOAD, MODE_SHL and MODE_SHR
  - default WIDTH and STEP constants
- One sub-module, shreg_iter_cnt, implements the cnt/done logic. It is parametrised by ITER, takes clr (LOAD) and inc (SHL and not done), and is reusable by the sqrt controller.
- Parameter legality (WIDTH % STEP == 0, STEP < WIDTH, ITER ≥ 1) is checked at elaboration.

## Test plan
All scenarios use WIDTH=8, STEP=2, ITER=4, with SHREG_SOUT_EN defined unless stated.
- LOAD 0xA5, then SHL ×4 with sin=11, 00, 01, 10 → q=0x97, 0x5C, 0x71, 0xC6; cnt=1..4; done=1 only after the 4th; sout=10, 10, 01, 01.
- A 5th SHL after done (sin=11) → q stays 0xC6, cnt stays 4, done stays 1, sout stays 01.
- SHR with q=0xC6 and done=1 → q=0x63; cnt=4 and done=1 unchanged.
- LOAD 0x3C while done=1 → next cycle q=0x3C, cnt=0, done=0, sout=00.
- rst pulsed mid-cycle after 2 SHLs → q=0, cnt=0, done=0 immediately, before the next clk edge. A HOLD after release keeps all of them at 0.
- Build without SHREG_SOUT_EN and rerun the first scenario → identical q, cnt and done; sout port absent.

Source files
------------

// File: rtl/sqrt_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// shreg_pkg
// Shared definitions for the sqrt datapath shift register.
//   shreg_mode_t : operation select presented by the controller every cycle
//                  (HOLD is the idle encoding).
//   SHREG_WIDTH  : default register width.
//   SHREG_STEP   : default bits shifted in per left shift.
// ---------------------------------------------------------------------------
package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } shreg_mode_t;

  localparam int SHREG_WIDTH = 16;
  localparam int SHREG_STEP  = 2;

endpackage : shreg_pkg

// File: rtl/sqrt_shift_reg_if.sv
// ---------------------------------------------------------------------------
// sqrt_shift_reg_if
// Bundle between the sqrt controller (master) and one shift register (slave).
// Optional macro: SHREG_SOUT_EN adds the sout signal.
//   mode : operation select (controller -> register)
//   d    : parallel load data
//   sin  : serial fill bits, entering at the LSBs on a left shift
//   q    : register contents
//   cnt  : completed left-shift count, saturates at ITER
//   done : cnt == ITER
//   sout : bits most recently shifted out of the MSBs (SHREG_SOUT_EN only)
//
// Handshake: there is none. The master presents mode every cycle and the
// slave acts on it at the next rising clk edge; outputs reflect the result
// one cycle later. MODE_HOLD is the idle encoding.
// ---------------------------------------------------------------------------
interface sqrt_shift_reg_if
  import shreg_pkg::*;
#(
  parameter int WIDTH = SHREG_WIDTH,
  parameter int STEP  = SHREG_STEP,
  parameter int ITER  = WIDTH / STEP
) ();

  localparam int CW = $clog2(ITER + 1);

  shreg_mode_t        mode;
  logic [WIDTH-1:0]   d;
  logic [STEP-1:0]    sin;
  logic [WIDTH-1:0]   q;
  logic [CW-1:0]      cnt;
  logic               done;
`ifdef SHREG_SOUT_EN
  logic [STEP-1:0]    sout;
`endif

`ifdef SHREG_SOUT_EN
  modport master (output mode, d, sin, input q, cnt, done, sout);
  modport slave  (input mode, d, sin, output q, cnt, done, sout);
`else
  modport master (output mode, d, sin, input q, cnt, done);
  modport slave  (input mode, d, sin, output q, cnt, done);
`endif

endinterface : sqrt_shift_reg_if

// File: rtl/sqrt_shift_reg_iter_cnt.sv
// ---------------------------------------------------------------------------
// shreg_iter_cnt
// Saturating iteration counter with registered completion flag. Reusable by
// the sqrt controller to sequence any fixed-length iteration.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   clr  : restart the sequence (cnt <= 0, done <= 0); wins over inc
//   inc  : count one completed iteration; ignored once done is set
//   cnt  : completed iteration count, never exceeds ITER
//   done : registered, high once cnt == ITER
// ---------------------------------------------------------------------------
module shreg_iter_cnt #(
  parameter int ITER = 8,
  parameter int CW   = $clog2(ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          done
);

  if (ITER < 1) begin : g_bad_iter
    $error("shreg_iter_cnt: ITER must be >= 1");
  end

  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (inc && !r_done) begin
      // done rises on the same edge that cnt reaches ITER
      r_cnt  <= w_cnt_nxt;
      r_done <= (w_cnt_nxt == CW'(ITER));
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule : shreg_iter_cnt

// File: rtl/sqrt_shift_reg.sv
// ---------------------------------------------------------------------------
// sqrt_shift_reg
// Multi-mode operand register for the square-root datapath: load, hold,
// left shift by STEP with serial fill, logical right shift by one, plus an
// iteration counter over left shifts.
// Optional macro: SHREG_SOUT_EN adds the sout register/port.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears q, cnt, done, sout)
//   bus : sqrt_shift_reg_if.slave (mode, d, sin in; q, cnt, done, sout out)
// ---------------------------------------------------------------------------
module sqrt_shift_reg
  import shreg_pkg::*;
#(
  parameter int WIDTH = SHREG_WIDTH,
  parameter int STEP  = SHREG_STEP,
  parameter int ITER  = WIDTH / STEP
) (
  input  logic               clk,
  input  logic               rst,
  sqrt_shift_reg_if.slave    bus
);

  localparam int CW = $clog2(ITER + 1);

  if (STEP < 1 || STEP >= WIDTH) begin : g_bad_step
    $error("sqrt_shift_reg: STEP must satisfy 1 <= STEP < WIDTH");
  end
  if ((WIDTH % STEP) != 0) begin : g_bad_mult
    $error("sqrt_shift_reg: WIDTH must be a multiple of STEP");
  end
  if (ITER < 1) begin : g_bad_iter
    $error("sqrt_shift_reg: ITER must be >= 1");
  end

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    w_cnt;
  logic             w_done;
  logic             w_clr;
  logic             w_shl;

  assign w_clr = (bus.mode == MODE_LOAD);
  // A left shift after completion is ignored entirely.
  assign w_shl = (bus.mode == MODE_SHL) && !w_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      case (bus.mode)
        MODE_LOAD: r_q <= bus.d;
        MODE_SHL:  if (!w_done) r_q <= {r_q[WIDTH-STEP-1:0], bus.sin};
        MODE_SHR:  r_q <= {1'b0, r_q[WIDTH-1:1]};
        default:   r_q <= r_q;
      endcase
    end
  end

`ifdef SHREG_SOUT_EN
  logic [STEP-1:0] r_sout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sout <= '0;
    end else if (w_clr) begin
      r_sout <= '0;
    end else if (w_shl) begin
      r_sout <= r_q[WIDTH-1:WIDTH-STEP];
    end
  end

  assign bus.sout = r_sout;
`endif

  shreg_iter_cnt #(
    .ITER (ITER),
    .CW   (CW)
  ) u_iter_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .inc  (w_shl),
    .cnt  (w_cnt),
    .done (w_done)
  );

  assign bus.q    = r_q;
  assign bus.cnt  = w_cnt;
  assign bus.done = w_done;

endmodule : sqrt_shift_reg

// File: tb/tb_sqrt_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_sqrt_shift_reg
// Directed scenarios followed by randomized operations for sqrt_shift_reg
// with WIDTH=8, STEP=2, ITER=4. A behavioural model (plain integer
// arithmetic) predicts q, cnt, done and, with SHREG_SOUT_EN, sout.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sqrt_shift_reg;
  import shreg_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int IT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt_shift_reg_if #(.WIDTH(W), .STEP(S), .ITER(IT)) bus ();

  sqrt_shift_reg #(.WIDTH(W), .STEP(S), .ITER(IT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  int m_q    = 0;
  int m_cnt  = 0;
  int m_done = 0;
  int m_sout = 0;

  function automatic void model_reset();
    m_q = 0; m_cnt = 0; m_done = 0; m_sout = 0;
  endfunction

  function automatic void model_op(shreg_mode_t m, int dd, int ss);
    int wmask;
    int smask;
    wmask = (1 << W) - 1;
    smask = (1 << S) - 1;
    case (m)
      MODE_LOAD: begin
        m_q = dd & wmask; m_cnt = 0; m_done = 0; m_sout = 0;
      end
      MODE_SHL: begin
        if (m_done == 0) begin
          m_sout = (m_q >> (W - S)) & smask;
          m_q    = ((m_q << S) | (ss & smask)) & wmask;
          m_cnt  = m_cnt + 1;
          m_done = (m_cnt == IT) ? 1 : 0;
        end
      end
      MODE_SHR: m_q = m_q / 2;
      default: ;
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},    32'(bus.q),    32'(m_q));
    check({tag, ".cnt"},  32'(bus.cnt),  32'(m_cnt));
    check({tag, ".done"}, 32'(bus.done), 32'(m_done));
`ifdef SHREG_SOUT_EN
    check({tag, ".sout"}, 32'(bus.sout), 32'(m_sout));
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, let the next posedge act, check at the
  // following negedge.
  task automatic step(input shreg_mode_t m, input int dd, input int ss, input string tag);
    bus.mode = m;
    bus.d    = W'(dd);
    bus.sin  = S'(ss);
    model_op(m, dd, ss);
    @(negedge clk);
    check_model(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0] shl_q [4];
  logic [1:0] shl_sin [4];
  logic [1:0] shl_sout [4];
  int r;

  initial begin
    shl_sin  = '{2'b11, 2'b00, 2'b01, 2'b10};
    shl_q    = '{8'h97, 8'h5C, 8'h71, 8'hC6};
    shl_sout = '{2'b10, 2'b10, 2'b01, 2'b01};

    bus.mode = MODE_HOLD;
    bus.d    = '0;
    bus.sin  = '0;
    repeat (3) @(negedge clk);
    check("reset.q", 32'(bus.q), 32'h0);
    check("reset.cnt", 32'(bus.cnt), 32'h0);
    check("reset.done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    model_reset();

    // Load then four left shifts
    step(MODE_LOAD, 8'hA5, 0, "load_a5");
    check("load_a5.q_lit", 32'(bus.q), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      step(MODE_SHL, 0, int'(shl_sin[i]), "shl");
      check("shl.q_lit", 32'(bus.q), 32'(shl_q[i]));
      check("shl.cnt_lit", 32'(bus.cnt), 32'(i + 1));
      check("shl.done_lit", 32'(bus.done), (i == 3) ? 32'h1 : 32'h0);
`ifdef SHREG_SOUT_EN
      check("shl.sout_lit", 32'(bus.sout), 32'(shl_sout[i]));
`endif
    end

    // Fifth shift after done is ignored
    step(MODE_SHL, 0, 3, "shl_sat");
    check("shl_sat.q_lit", 32'(bus.q), 32'hC6);
    check("shl_sat.cnt_lit", 32'(bus.cnt), 32'h4);
    check("shl_sat.done_lit", 32'(bus.done), 32'h1);

    // Right shift while done
    step(MODE_SHR, 0, 0, "shr_done");
    check("shr_done.q_lit", 32'(bus.q), 32'h63);
    check("shr_done.done_lit", 32'(bus.done), 32'h1);

    // Reload while done restarts
    step(MODE_LOAD, 8'h3C, 0, "reload");
    check("reload.q_lit", 32'(bus.q), 32'h3C);
    check("reload.cnt_lit", 32'(bus.cnt), 32'h0);
    check("reload.done_lit", 32'(bus.done), 32'h0);

    // Two shifts, then asynchronous reset between edges
    step(MODE_SHL, 0, 1, "pre_rst1");
    step(MODE_SHL, 0, 2, "pre_rst2");
    bus.mode = MODE_HOLD;
    #2 rst = 1'b1;
    #1;
    check("async_rst.q", 32'(bus.q), 32'h0);
    check("async_rst.cnt", 32'(bus.cnt), 32'h0);
    check("async_rst.done", 32'(bus.done), 32'h0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    step(MODE_HOLD, 0, 0, "post_rst_hold");
    check("post_rst_hold.q_lit", 32'(bus.q), 32'h0);

    // Randomized operations, biased towards left shifts
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      step(MODE_LOAD, $urandom_range(0, 255), 0, "rnd_load");
      else if (r <= 2) step(MODE_HOLD, $urandom_range(0, 255), $urandom_range(0, 3), "rnd_hold");
      else if (r == 3) step(MODE_SHR, $urandom_range(0, 255), $urandom_range(0, 3), "rnd_shr");
      else             step(MODE_SHL, $urandom_range(0, 255), $urandom_range(0, 3), "rnd_shl");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sqrt_shift_reg
